if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline. It generates the fetch PC, issues one-at-a-time requests to the instruction SRAM-like port, and buffers the returned word. It hands instructions to the decode stage over the valid/allowin handshake and applies taken-branch redirects while honouring the MIPS delay slot. It is the transmitting end of the IF→ID interface, and it supplies the ID-aligned instruction word that decode consumes combinationally.

## Interface
Parameters:
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_allowin_in  in  1  decode can accept an instruction this cycle.
- if_valid_out  out  1  buffered instruction available to decode.
- if_PC_out  out  32  PC of the buffered instruction.
- if_NNPC_out  out  32  if_PC_out + 8 (link address).
- if_Instruct_out  out  32  instruction word of the instruction most recently accepted by decode.
- if_adel_out  out  1  fetch address error flag of the buffered instruction.
- br_taken_in  in  1  one-cycle pulse: branch/jump leaving decode is taken.
- br_target_in  in  32  redirect target, sampled with br_taken_in.
- inst_req  out  1  fetch request.
- inst_addr  out  32  fetch address.
- inst_addr_ok  in  1  request accepted; handshake is inst_req && inst_addr_ok.
- inst_rdata  in  32  returned word, valid with inst_data_ok.
- inst_data_ok  in  1  read data return.

## Operation
- Handshake to decode: transfer when if_valid_out && id_allowin_in.
- FSM states:
  - IDLE: first cycle after reset.
  - REQ: inst_req=1, waiting for inst_addr_ok.
  - WAIT: waiting for inst_data_ok.
  - HOLD: word buffered, if_valid_out=1.
- Transitions:
  - IDLE→REQ unconditionally.
  - REQ→WAIT on addr_ok.
  - WAIT→HOLD on data_ok, which captures inst_rdata into the buffer.
  - HOLD→REQ on handshake.
- At most one request outstanding.
- inst_addr holds the fetch PC and stays stable in REQ until accepted.
- Fetch PC update on leaving HOLD:
  - redirect pending or br_taken_in this cycle → target;
  - else PC+4 (32-bit wrap, no carry out).
- Delay slot: when br_taken_in pulses, the instruction IF holds or has in flight is the delay slot, as is the one being handed over the same cycle. It is always delivered. Only the next request address is replaced.
- Redirect register: set on br_taken_in, cleared when the redirected request leaves HOLD→REQ. A second br_taken_in while pending overwrites the target.
- if_Instruct_out: on each handshake edge, loaded from the buffer. It tracks decode's registered PC, so it must stay stable until the next handshake.
- inst_data_ok in IDLE/REQ/HOLD is ignored.

## Timing
- Reset values:
  - state IDLE, fetch PC = RESET_PC;
  - if_valid_out=0, inst_req=0;
  - if_PC_out=RESET_PC, if_NNPC_out=RESET_PC+8;
  - if_Instruct_out=0, if_adel_out=0;
  - redirect pending=0.
- First inst_req asserts in cycle 1 after rst deasserts.
- Best case: addr_ok in REQ cycle, data_ok the next cycle, if_valid_out the cycle after that. Throughput is one instruction per 3 cycles with id_allowin_in tied high.
- Stalls:
  - id_allowin_in=0 in HOLD keeps all outputs and buffer unchanged.
  - Wait states on addr_ok/data_ok extend REQ/WAIT indefinitely.
- Reset mid-operation (any state) returns to reset values immediately. A data_ok for the abandoned request is discarded by the IDLE/REQ rule.

## Configuration
- IF_ADEL_CHECK_EN defined:
  - a fetch PC with PC[1:0]≠0 issues no request;
  - the FSM goes REQ→HOLD directly next cycle with buffer=32'h0 and if_adel_out=1;
  - the redirect and sequencing rules are unchanged.
- Undefined:
  - if_adel_out tied 0;
  - the address is issued unmodified.

## Test plan
- Reset, memory answers addr_ok/data_ok immediately, id_allowin_in=1 → inst_addr sequence BFC00000, BFC00004, BFC00008 every 3 cycles; if_NNPC_out=if_PC_out+8.
- Hold id_allowin_in=0 for 5 cycles in HOLD → if_valid_out stays 1, if_PC_out and if_Instruct_out unchanged, inst_req=0.
- Handshake instruction 0x24080005 → if_Instruct_out=0x24080005 starting the next cycle and stable until the next handshake.
- br_taken_in pulse with target 0x80001000 while IF holds PC 0xBFC00010 → 0xBFC00010 delivered, next inst_addr=0x80001000.
- Assert rst during WAIT, then data_ok arrives in IDLE → if_valid_out stays 0, next request is to RESET_PC.
- With IF_ADEL_CHECK_EN, redirect to 0x80001002 → no inst_req for it, if_adel_out=1, buffer 0.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: MIPS instruction-fetch stage with a single outstanding SRAM-like request and delay-slot aware redirect.
// Optional feature macro IF_ADEL_CHECK_EN: a misaligned fetch PC raises if_adel_out instead of issuing a request.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_allowin_in,
  output logic        if_valid_out,
  output logic [31:0] if_PC_out,
  output logic [31:0] if_NNPC_out,
  output logic [31:0] if_Instruct_out,
  output logic        if_adel_out,
  input  logic        br_taken_in,
  input  logic [31:0] br_target_in,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_rdata,
  input  logic        inst_data_ok
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] fetch_pc;
  logic [31:0] nnpc;
  logic [31:0] next_pc;
  logic [31:0] buf_word;
  logic [31:0] instruct;
  logic [31:0] redirect_target;
  logic        redirect_pending;
  logic        handshake;
  logic        misaligned;

  assign handshake = if_valid_out && id_allowin_in;

`ifdef IF_ADEL_CHECK_EN
  logic buf_adel;

  assign misaligned  = (fetch_pc[1:0] != 2'b00);
  assign if_adel_out = buf_adel;

  // Address-error flag travels with the buffered word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_adel <= 1'b0;
    end else if (state == WAIT && inst_data_ok) begin
      buf_adel <= 1'b0;
    end else if (state == REQ && misaligned) begin
      buf_adel <= 1'b1;
    end
  end
`else
  assign misaligned  = 1'b0;
  assign if_adel_out = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        if (misaligned) begin
          state_next = HOLD;
        end else if (inst_addr_ok) begin
          state_next = WAIT;
        end else begin
          state_next = REQ;
        end
      end
      WAIT: begin
        if (inst_data_ok) begin
          state_next = HOLD;
        end else begin
          state_next = WAIT;
        end
      end
      HOLD: begin
        if (handshake) begin
          state_next = REQ;
        end else begin
          state_next = HOLD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    inst_req     = 1'b0;
    if_valid_out = 1'b0;
    case (state)
      REQ:     inst_req     = !misaligned;
      HOLD:    if_valid_out = 1'b1;
      default: begin
        inst_req     = 1'b0;
        if_valid_out = 1'b0;
      end
    endcase
  end

  // A pulse arriving in the handover cycle wins over an older pending target.
  always_comb begin
    next_pc = fetch_pc + 32'd4;
    if (br_taken_in) begin
      next_pc = br_target_in;
    end else if (redirect_pending) begin
      next_pc = redirect_target;
    end else begin
      next_pc = fetch_pc + 32'd4;
    end
  end

  // Fetch PC and link address advance only when the held word is handed over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      nnpc     <= RESET_PC + 32'd8;
    end else if (handshake) begin
      fetch_pc <= next_pc;
      nnpc     <= next_pc + 32'd8;
    end
  end

  // Redirect register: the delay slot is whatever is held or in flight, so the target waits for the next handover.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_pending <= 1'b0;
      redirect_target  <= 32'h0000_0000;
    end else if (handshake) begin
      redirect_pending <= 1'b0;
    end else if (br_taken_in) begin
      redirect_pending <= 1'b1;
      redirect_target  <= br_target_in;
    end
  end

  // Return buffer; data_ok outside WAIT belongs to no live request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_word <= 32'h0000_0000;
    end else if (state == WAIT && inst_data_ok) begin
      buf_word <= inst_rdata;
    end else if (state == REQ && misaligned) begin
      buf_word <= 32'h0000_0000;
    end
  end

  // Decode-aligned instruction word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruct <= 32'h0000_0000;
    end else if (handshake) begin
      instruct <= buf_word;
    end
  end

  assign if_PC_out       = fetch_pc;
  assign if_NNPC_out     = nnpc;
  assign inst_addr       = fetch_pc;
  assign if_Instruct_out = instruct;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed plus randomized bench for if_stage with a transaction-level fetch/delivery reference model.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk;
  logic        rst;
  logic        id_allowin_in;
  logic        if_valid_out;
  logic [31:0] if_PC_out;
  logic [31:0] if_NNPC_out;
  logic [31:0] if_Instruct_out;
  logic        if_adel_out;
  logic        br_taken_in;
  logic [31:0] br_target_in;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_allowin_in   (id_allowin_in),
    .if_valid_out    (if_valid_out),
    .if_PC_out       (if_PC_out),
    .if_NNPC_out     (if_NNPC_out),
    .if_Instruct_out (if_Instruct_out),
    .if_adel_out     (if_adel_out),
    .br_taken_in     (br_taken_in),
    .br_target_in    (br_target_in),
    .inst_req        (inst_req),
    .inst_addr       (inst_addr),
    .inst_addr_ok    (inst_addr_ok),
    .inst_rdata      (inst_rdata),
    .inst_data_ok    (inst_data_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_asserts = 0;
  int fails     = 0;

  // Reference model: memory contents, outstanding request, expected fetch/delivery.
  logic        mem_pending;
  logic [31:0] mem_addr;
  logic [31:0] exp_fetch;
  logic [31:0] held_pc;
  logic [31:0] exp_instr;
  logic [31:0] tgt_saved;
  bit          tgt_pending;
  bit          exp_adel;
  bit          stall_prev;
  logic [31:0] prev_pc;
  int          since_hs;
  int          n_hs;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'hBFC0_000C) return 32'h2408_0005;
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check at the negedge, drive, advance the model at the posedge, return at the next negedge.
  task automatic cycle(input bit allow, input int ao_pct, input int do_pct,
                       input bit br, input logic [31:0] tgt, input bit stray);
    logic        v, rq;
    logic [31:0] a, pc;
    bit          ao, dok, hs;
    v  = if_valid_out;
    rq = inst_req;
    a  = inst_addr;
    pc = if_PC_out;
    check("nnpc", if_NNPC_out, pc + 32'd8);
    check("instr", if_Instruct_out, exp_instr);
    if (rq) begin
      check("one_outstanding", {31'd0, mem_pending}, 32'd0);
      check("req_addr", a, exp_fetch);
    end
    if (v) begin
      check("hold_pc", pc, held_pc);
      check("adel", {31'd0, if_adel_out}, {31'd0, exp_adel});
    end
    if (stall_prev) begin
      check("stall_valid", {31'd0, v}, 32'd1);
      check("stall_pc", pc, prev_pc);
      check("stall_req", {31'd0, rq}, 32'd0);
    end
    ao  = ($urandom_range(99) < ao_pct);
    dok = stray || (mem_pending && ($urandom_range(99) < do_pct));
    id_allowin_in = allow;
    inst_addr_ok  = ao;
    inst_data_ok  = dok;
    inst_rdata    = (mem_pending && dok) ? memword(mem_addr) : $urandom();
    br_taken_in   = br;
    br_target_in  = tgt;
    @(posedge clk);
    hs = v && allow;
    if (hs) begin
      exp_instr   = memword(held_pc);
      exp_fetch   = br ? tgt : (tgt_pending ? tgt_saved : held_pc + 32'd4);
      tgt_pending = 1'b0;
      n_hs++;
      since_hs = 0;
    end else begin
      if (br) begin
        tgt_pending = 1'b1;
        tgt_saved   = tgt;
      end
      since_hs++;
    end
    if (mem_pending && dok) begin
      mem_pending = 1'b0;
      held_pc     = mem_addr;
    end
    if (rq && ao) begin
      mem_pending = 1'b1;
      mem_addr    = a;
    end
    stall_prev = v && !allow;
    prev_pc    = pc;
    @(negedge clk);
  endtask

  // Called at a negedge: assert reset, check reset values, release at the next negedge.
  task automatic apply_reset();
    rst = 1'b1;
    id_allowin_in = 1'b0;
    inst_addr_ok  = 1'b0;
    inst_data_ok  = 1'b0;
    br_taken_in   = 1'b0;
    #1;
    check("rst_valid", {31'd0, if_valid_out}, 32'd0);
    check("rst_req", {31'd0, inst_req}, 32'd0);
    check("rst_pc", if_PC_out, RESET_PC);
    check("rst_nnpc", if_NNPC_out, RESET_PC + 32'd8);
    check("rst_instr", if_Instruct_out, 32'd0);
    check("rst_adel", {31'd0, if_adel_out}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_fetch   = RESET_PC;
    held_pc     = RESET_PC;
    mem_pending = 1'b0;
    tgt_pending = 1'b0;
    exp_instr   = 32'd0;
    exp_adel    = 1'b0;
    stall_prev  = 1'b0;
    since_hs    = 0;
  endtask

  task automatic run_to_valid(input string tag);
    int k;
    k = 0;
    while (!if_valid_out && k < 60) begin
      cycle(1'b0, 100, 100, 1'b0, 32'd0, 1'b0);
      k++;
    end
    check(tag, {31'd0, if_valid_out}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    id_allowin_in = 1'b0;
    inst_addr_ok  = 1'b0;
    inst_data_ok  = 1'b0;
    inst_rdata    = 32'd0;
    br_taken_in   = 1'b0;
    br_target_in  = 32'd0;
    n_hs = 0;
    tgt_saved = 32'd0;
    mem_addr = 32'd0;
    prev_pc = 32'd0;
    @(negedge clk);
    apply_reset();

    // Zero-wait memory: request every 3 cycles, sequential addresses.
    for (int c = 0; c < 10; c++) begin
      check("tim_req", {31'd0, inst_req}, {31'd0, (c % 3) == 1});
      check("tim_valid", {31'd0, if_valid_out}, {31'd0, (c % 3) == 0 && c != 0});
      if (c == 1) check("seq_addr0", inst_addr, 32'hBFC0_0000);
      if (c == 4) check("seq_addr1", inst_addr, 32'hBFC0_0004);
      if (c == 7) check("seq_addr2", inst_addr, 32'hBFC0_0008);
      cycle(1'b1, 100, 100, 1'b0, 32'd0, 1'b0);
    end

    // Stall five cycles on BFC0000C, then hand over 0x24080005.
    run_to_valid("reach_0c");
    check("pc_0c", if_PC_out, 32'hBFC0_000C);
    for (int s = 0; s < 5; s++) cycle(1'b0, 100, 100, 1'b0, 32'd0, 1'b0);
    cycle(1'b1, 100, 100, 1'b0, 32'd0, 1'b0);
    check("instr_2408", if_Instruct_out, 32'h2408_0005);
    run_to_valid("reach_10");
    check("instr_stable", if_Instruct_out, 32'h2408_0005);
    check("pc_10", if_PC_out, 32'hBFC0_0010);

    // Branch while holding BFC00010: delay slot delivered, next fetch redirected.
    cycle(1'b0, 100, 100, 1'b1, 32'h8000_1000, 1'b0);
    cycle(1'b1, 100, 100, 1'b0, 32'd0, 1'b0);
    check("dslot_instr", if_Instruct_out, memword(32'hBFC0_0010));
    check("redir_req", {31'd0, inst_req}, 32'd1);
    check("redir_addr", inst_addr, 32'h8000_1000);

    // Reset while WAIT; stray data_ok in IDLE and REQ must be dropped.
    cycle(1'b1, 100, 0, 1'b0, 32'd0, 1'b0);
    check("in_wait", {30'd0, inst_req, if_valid_out}, 32'd0);
    apply_reset();
    cycle(1'b1, 0, 0, 1'b0, 32'd0, 1'b1);
    check("stray_valid0", {31'd0, if_valid_out}, 32'd0);
    check("stray_req", {31'd0, inst_req}, 32'd1);
    check("stray_addr", inst_addr, RESET_PC);
    cycle(1'b1, 0, 0, 1'b0, 32'd0, 1'b1);
    check("stray_valid1", {31'd0, if_valid_out}, 32'd0);

    // Randomized traffic with wait states, stalls and branches.
    for (int r = 0; r < 2500; r++) begin
      cycle($urandom_range(99) < 70, $urandom_range(100, 20), $urandom_range(100, 20),
            $urandom_range(99) < 6, $urandom() & 32'hFFFF_FFFC, 1'b0);
      if (since_hs > 200) begin
        check("liveness", since_hs, 32'd0);
        since_hs = 0;
      end
    end
    check("handshakes", {31'd0, n_hs > 100}, 32'd1);

`ifdef IF_ADEL_CHECK_EN
    // Misaligned redirect: no request, flagged zero word.
    run_to_valid("adel_pre");
    cycle(1'b0, 100, 100, 1'b1, 32'h8000_1002, 1'b0);
    cycle(1'b1, 100, 100, 1'b0, 32'd0, 1'b0);
    held_pc  = 32'h8000_1002;
    exp_adel = 1'b1;
    check("adel_noreq", {31'd0, inst_req}, 32'd0);
    cycle(1'b0, 100, 100, 1'b0, 32'd0, 1'b0);
    check("adel_valid", {31'd0, if_valid_out}, 32'd1);
    check("adel_flag", {31'd0, if_adel_out}, 32'd1);
    cycle(1'b1, 100, 100, 1'b0, 32'd0, 1'b0);
    exp_instr = 32'd0;
    check("adel_word", if_Instruct_out, 32'd0);
    apply_reset();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, fails);
    $finish;
  end

endmodule
